instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the immediate generator. Takes RV32I instruction fields plus a
//  signed immediate, or an absolute branch/jump target, and packs them into a
//  32-bit instruction word. Feeds the program loader that fills instruction
//  memory. Keeps its own PC (+4 per accepted request) so SB/UJ offsets are
//  computed as target - pc. 2-stage valid/ready pipeline with range/alignment
//  checking.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC counter value after reset
//  NOP_WORD  32'h0000_0013  word emitted on error (addi x0,x0,0)
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous reset, active low
//  in_valid   in   1   request valid
//  in_ready   out  1   request accepted when in_valid & in_ready
//  fmt        in   3   0=R 1=I 2=S 3=SB 4=U 5=UJ, 6..7 illegal
//  opcode     in   7   placed at [6:0]
//  rd         in   5   [11:7]  (R/I/U/UJ)
//  funct3     in   3   [14:12] (R/I/S/SB)
//  rs1        in   5   [19:15] (R/I/S/SB)
//  rs2        in   5   [24:20] (R/S/SB)
//  funct7     in   7   [31:25] (R only)
//  imm        in   32  I/S: signed imm; U: value with [11:0]=0; SB/UJ: absolute target
//  pc_load    in   1   load PC counter with pc_init
//  pc_init    in   32  new PC value
//  out_valid  out  1   encoded word valid
//  out_ready  in   1   consumer accepts when out_valid & out_ready
//  out_ins    out  32  encoded instruction
//  out_pc     out  32  PC the word belongs to
//  out_err    out  1   request rejected; out_ins = NOP_WORD
//  err_code   out  2   0 ok, 1 range, 2 misaligned (SB/UJ), 3 illegal fmt
// BEHAVIOUR
//  Reset (async, rst_n=0): pc_q=RESET_PC; both stage valids 0; out_valid=0;
//   out_ins=0, out_pc=0, out_err=0, err_code=0. Reset mid-operation drops all
//   in-flight requests.
//  Stage 1 (on accept): registers fields and the request PC; computes
//   off = imm - req_pc (32-bit wrap) for SB/UJ.
//  Stage 2: scatters bits, checks, drives out_* registers.
//  Latency: accept in cycle N -> out_valid in cycle N+2 when unstalled.
//  Throughput: 1/cycle. Stage advances when its successor is empty or being
//   drained. in_ready = !s1_valid | s1_advance (combinational, no in_valid path).
//  out_* held stable while out_valid & !out_ready.
//  PC: req_pc = pc_load ? pc_init : pc_q. On accept, pc_q <= req_pc+4.
//   On pc_load without accept, pc_q <= pc_init. Rejected requests still
//   consume +4.
//  Packing: I: imm[11:0]->[31:20]. S: imm[11:5]->[31:25], imm[4:0]->[11:7].
//   SB: off[12]->31, off[10:5]->[30:25], off[4:1]->[11:8], off[11]->7.
//   U: imm[31:12]->[31:12].
//   UJ: off[20]->31, off[10:1]->[30:21], off[11]->20, off[19:12]->[19:12].
//  Checks: I/S range if imm[31:11] not all equal. SB range if off[31:12] not all
//   equal; misaligned if off[0]. UJ range if off[31:20] not all equal;
//   misaligned if off[0]. U range if imm[11:0]!=0. fmt 6/7 -> code 3.
//   Misaligned takes precedence over range.
//  On error: out_ins=NOP_WORD, out_err=1, out_pc=req_pc. Pipeline does not stall.
// TESTING
//  I: opcode 0x13, rd 5, rs1 5, f3 0, imm 1 -> 0x00128293, err 0, 2 cycles.
//  I: rd 29, rs1 29, imm 1 -> 0x001E8E93; back-to-back with previous at 1/cycle.
//  SB: pc_load 0x0C; beq rs1 1, rs2 2, target 0x14 -> 0x00208463, out_pc 0x0C.
//  UJ: pc_load 0x7C; jal rd 1, target 0x78 -> 0xFFDFF0EF.
//  Errors: I imm 2048 -> 0x00000013, code 1. SB target pc+3 -> code 2.
//   fmt 7 -> code 3. PC still advances by 4 per request.
//  Stall: out_ready=0 for 5 cycles, 3 requests -> in_ready drops after 2,
//   out_* stable, all 3 delivered in order; rst_n pulse mid-stall clears all.

Source files
------------

// File: rtl/instr_encoder.sv
// Packs RV32I fields plus an immediate or absolute branch/jump target into a 32-bit instruction word.
// Latency: 2 cycles from accept to out_valid when unstalled; throughput 1 word per cycle.
// Backpressure: out_* held while out_valid & !out_ready; in_ready drops when both stages are full.
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready         request handshake; in_ready has no combinational path from in_valid
//   fmt, opcode, rd, funct3,
//   rs1, rs2, funct7, imm       instruction fields; imm is the absolute target for SB/UJ
//   pc_load, pc_init            overwrite the internal PC counter (also used as this request's PC)
//   out_valid / out_ready       result handshake
//   out_ins, out_pc             encoded word and the PC it belongs to
//   out_err, err_code           0 ok, 1 range, 2 misaligned, 3 illegal fmt (out_ins = NOP_WORD on error)
module instr_encoder #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  input  logic        pc_load,
  input  logic [31:0] pc_init,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ins,
  output logic [31:0] out_pc,
  output logic        out_err,
  output logic [1:0]  err_code
);

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_S  = 3'd2;
  localparam logic [2:0] FMT_SB = 3'd3;
  localparam logic [2:0] FMT_U  = 3'd4;
  localparam logic [2:0] FMT_UJ = 3'd5;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_FMT   = 2'd3;

  // PC counter
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc;

  // Stage 1 registers
  logic        s1_vld_q, s1_vld_d;
  logic [2:0]  s1_fmt_q, s1_fmt_d;
  logic [6:0]  s1_opcode_q, s1_opcode_d;
  logic [4:0]  s1_rd_q, s1_rd_d;
  logic [2:0]  s1_f3_q, s1_f3_d;
  logic [4:0]  s1_rs1_q, s1_rs1_d;
  logic [4:0]  s1_rs2_q, s1_rs2_d;
  logic [6:0]  s1_f7_q, s1_f7_d;
  logic [31:0] s1_val_q, s1_val_d;  // imm for R/I/S/U, target - pc for SB/UJ
  logic [31:0] s1_pc_q, s1_pc_d;

  // Stage 2 (output) registers
  logic        out_vld_q, out_vld_d;
  logic [31:0] out_ins_q, out_ins_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        out_err_q, out_err_d;
  logic [1:0]  err_code_q, err_code_d;

  logic        accept;
  logic        s2_load;
  logic [31:0] enc_ins;
  logic [1:0]  enc_code;

  // Output stage loads when it is empty or being drained this cycle.
  assign s2_load  = s1_vld_q & (~out_vld_q | out_ready);
  assign in_ready = ~s1_vld_q | s2_load;
  assign accept   = in_valid & in_ready;
  assign req_pc   = pc_load ? pc_init : pc_q;

  assign out_valid = out_vld_q;
  assign out_ins   = out_ins_q;
  assign out_pc    = out_pc_q;
  assign out_err   = out_err_q;
  assign err_code  = err_code_q;

  // PC counter and stage 1 capture
  always_comb begin
    pc_d        = pc_q;
    s1_vld_d    = s1_vld_q;
    s1_fmt_d    = s1_fmt_q;
    s1_opcode_d = s1_opcode_q;
    s1_rd_d     = s1_rd_q;
    s1_f3_d     = s1_f3_q;
    s1_rs1_d    = s1_rs1_q;
    s1_rs2_d    = s1_rs2_q;
    s1_f7_d     = s1_f7_q;
    s1_val_d    = s1_val_q;
    s1_pc_d     = s1_pc_q;

    if (accept) begin
      // Every accepted request, rejected or not, consumes one word slot.
      pc_d        = req_pc + 32'd4;
      s1_vld_d    = 1'b1;
      s1_fmt_d    = fmt;
      s1_opcode_d = opcode;
      s1_rd_d     = rd;
      s1_f3_d     = funct3;
      s1_rs1_d    = rs1;
      s1_rs2_d    = rs2;
      s1_f7_d     = funct7;
      s1_val_d    = (fmt == FMT_SB || fmt == FMT_UJ) ? (imm - req_pc) : imm;
      s1_pc_d     = req_pc;
    end else begin
      if (pc_load) pc_d = pc_init;
      if (s2_load) s1_vld_d = 1'b0;
    end
  end

  // Bit scatter and range/alignment checks on stage 1 contents
  always_comb begin
    enc_ins  = '0;
    enc_code = ERR_OK;
    case (s1_fmt_q)
      FMT_R: begin
        enc_ins = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_opcode_q};
      end
      FMT_I: begin
        enc_ins = {s1_val_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_opcode_q};
        // Fits in 12 signed bits only if bits [31:11] are a pure sign extension.
        if (!((&s1_val_q[31:11]) | ~(|s1_val_q[31:11]))) enc_code = ERR_RANGE;
      end
      FMT_S: begin
        enc_ins = {s1_val_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_val_q[4:0], s1_opcode_q};
        if (!((&s1_val_q[31:11]) | ~(|s1_val_q[31:11]))) enc_code = ERR_RANGE;
      end
      FMT_SB: begin
        enc_ins = {s1_val_q[12], s1_val_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                   s1_val_q[4:1], s1_val_q[11], s1_opcode_q};
        if (!((&s1_val_q[31:12]) | ~(|s1_val_q[31:12]))) enc_code = ERR_RANGE;
        // Misalignment is reported in preference to range.
        if (s1_val_q[0]) enc_code = ERR_ALIGN;
      end
      FMT_U: begin
        enc_ins = {s1_val_q[31:12], s1_rd_q, s1_opcode_q};
        if (s1_val_q[11:0] != 12'd0) enc_code = ERR_RANGE;
      end
      FMT_UJ: begin
        enc_ins = {s1_val_q[20], s1_val_q[10:1], s1_val_q[11], s1_val_q[19:12],
                   s1_rd_q, s1_opcode_q};
        if (!((&s1_val_q[31:20]) | ~(|s1_val_q[31:20]))) enc_code = ERR_RANGE;
        if (s1_val_q[0]) enc_code = ERR_ALIGN;
      end
      default: begin
        enc_code = ERR_FMT;
      end
    endcase
  end

  // Output register: load, drain, or hold stable under backpressure
  always_comb begin
    out_vld_d  = out_vld_q;
    out_ins_d  = out_ins_q;
    out_pc_d   = out_pc_q;
    out_err_d  = out_err_q;
    err_code_d = err_code_q;
    if (s2_load) begin
      out_vld_d  = 1'b1;
      out_ins_d  = (enc_code != ERR_OK) ? NOP_WORD : enc_ins;
      out_pc_d   = s1_pc_q;
      out_err_d  = (enc_code != ERR_OK);
      err_code_d = enc_code;
    end else if (out_ready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      s1_vld_q    <= 1'b0;
      s1_fmt_q    <= '0;
      s1_opcode_q <= '0;
      s1_rd_q     <= '0;
      s1_f3_q     <= '0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_f7_q     <= '0;
      s1_val_q    <= '0;
      s1_pc_q     <= '0;
      out_vld_q   <= 1'b0;
      out_ins_q   <= '0;
      out_pc_q    <= '0;
      out_err_q   <= 1'b0;
      err_code_q  <= '0;
    end else begin
      pc_q        <= pc_d;
      s1_vld_q    <= s1_vld_d;
      s1_fmt_q    <= s1_fmt_d;
      s1_opcode_q <= s1_opcode_d;
      s1_rd_q     <= s1_rd_d;
      s1_f3_q     <= s1_f3_d;
      s1_rs1_q    <= s1_rs1_d;
      s1_rs2_q    <= s1_rs2_d;
      s1_f7_q     <= s1_f7_d;
      s1_val_q    <= s1_val_d;
      s1_pc_q     <= s1_pc_d;
      out_vld_q   <= out_vld_d;
      out_ins_q   <= out_ins_d;
      out_pc_q    <= out_pc_d;
      out_err_q   <= out_err_d;
      err_code_q  <= err_code_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed spec vectors, stall/reset scenarios, then random traffic.
// Expected words come from an arithmetic reference model and a scoreboard queue.
// Output backpressure is randomised; held outputs are checked for stability.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        pc_load;
  logic [31:0] pc_init;
  logic        out_valid, out_ready;
  logic [31:0] out_ins, out_pc;
  logic        out_err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .pc_load(pc_load), .pc_init(pc_init),
    .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins), .out_pc(out_pc),
    .out_err(out_err), .err_code(err_code)
  );

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        err;
    logic [1:0]  code;
    logic [31:0] cyc;
  } rec_t;

  rec_t        sb_q[$];   // expected, in acceptance order
  rec_t        got_q[$];  // delivered words, for directed literal checks
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] mpc = 32'h0;   // model PC counter
  logic [31:0] cyc = 32'h0;
  logic [31:0] acc_cyc = 32'h0;
  logic        last_acc = 1'b0;
  logic        chk_lat = 1'b0;
  logic        stab_vld = 1'b0;
  rec_t        stab_r;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference encoder: field placement by shifts and masks, range by signed bounds.
  function automatic rec_t model(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                                 input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                                 input logic [6:0] f7, input logic [31:0] im, input logic [31:0] pc);
    rec_t        r;
    logic [31:0] off, w;
    int          soff, simm;
    logic [1:0]  c;
    off  = im - pc;
    soff = int'(off);
    simm = int'(im);
    w    = 32'(op);
    c    = 2'd0;
    case (f)
      3'd0: w = w | (32'(f7) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7);
      3'd1: begin
        w = w | ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7);
        if (simm < -2048 || simm > 2047) c = 2'd1;
      end
      3'd2: begin
        w = w | (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12)
              | ((im & 32'h1F) << 7);
        if (simm < -2048 || simm > 2047) c = 2'd1;
      end
      3'd3: begin
        w = w | (((off >> 12) & 32'h1) << 31) | (((off >> 5) & 32'h3F) << 25) | (32'(s2) << 20)
              | (32'(s1) << 15) | (32'(f3) << 12) | (((off >> 1) & 32'hF) << 8) | (((off >> 11) & 32'h1) << 7);
        if (soff < -4096 || soff > 4095) c = 2'd1;
        if (off[0]) c = 2'd2;
      end
      3'd4: begin
        w = w | (im & 32'hFFFF_F000) | (32'(d) << 7);
        if ((im % 32'd4096) != 0) c = 2'd1;
      end
      3'd5: begin
        w = w | (((off >> 20) & 32'h1) << 31) | (((off >> 1) & 32'h3FF) << 21)
              | (((off >> 11) & 32'h1) << 20) | (((off >> 12) & 32'hFF) << 12) | (32'(d) << 7);
        if (soff < -1048576 || soff > 1048575) c = 2'd1;
        if (off[0]) c = 2'd2;
      end
      default: c = 2'd3;
    endcase
    r.ins  = (c != 2'd0) ? 32'h0000_0013 : w;
    r.pc   = pc;
    r.err  = (c != 2'd0);
    r.code = c;
    r.cyc  = cyc;
    return r;
  endfunction

  // One clock: at the falling edge check delivery/stability and account for an accept,
  // then return just after the next rising edge so the caller can drive new inputs.
  task automatic cycle();
    rec_t e, g;
    logic [31:0] rpc;
    @(negedge clk);
    if (stab_vld) begin
      check_val("stall_vld", 32'(out_valid), 32'd1);
      check_val("stall_ins", out_ins, stab_r.ins);
      check_val("stall_pc", out_pc, stab_r.pc);
      check_val("stall_err", {30'd0, err_code}, {30'd0, stab_r.code});
    end
    stab_vld   = out_valid & ~out_ready;
    stab_r.ins = out_ins; stab_r.pc = out_pc; stab_r.code = err_code;
    if (out_valid && out_ready) begin
      g.ins = out_ins; g.pc = out_pc; g.err = out_err; g.code = err_code; g.cyc = cyc;
      got_q.push_back(g);
      if (sb_q.size() == 0) begin
        check_val("spurious_out", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("ins", out_ins, e.ins);
        check_val("pc", out_pc, e.pc);
        check_val("err", 32'(out_err), 32'(e.err));
        check_val("code", 32'(err_code), 32'(e.code));
        if (chk_lat) check_val("latency", cyc - e.cyc, 32'd2);
      end
    end
    last_acc = in_valid & in_ready;
    if (last_acc) begin
      rpc = pc_load ? pc_init : mpc;
      sb_q.push_back(model(fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, rpc));
      mpc     = rpc + 32'd4;
      acc_cyc = cyc;
    end else if (pc_load) begin
      mpc = pc_init;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [6:0] f7, input logic [31:0] im, input logic pl, input logic [31:0] pi);
    fmt = f; opcode = op; rd = d; funct3 = f3; rs1 = s1; rs2 = s2; funct7 = f7; imm = im;
    pc_load = pl; pc_init = pi; in_valid = 1'b1;
  endtask

  // Hold a request until accepted (bounded), then drop valid.
  task automatic req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                     input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [6:0] f7, input logic [31:0] im, input logic pl, input logic [31:0] pi);
    int n;
    set_req(f, op, d, f3, s1, s2, f7, im, pl, pi);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 50);
    if (!last_acc) check_val("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    pc_load  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic expect_out(input string tag, input logic [31:0] ins, input logic [31:0] pc, input logic [1:0] code);
    rec_t g;
    if (got_q.size() == 0) begin
      check_val({tag, "_missing"}, 32'd0, 32'd1);
    end else begin
      g = got_q.pop_front();
      check_val({tag, "_ins"}, g.ins, ins);
      check_val({tag, "_pc"}, g.pc, pc);
      check_val({tag, "_code"}, 32'(g.code), 32'(code));
      check_val({tag, "_err"}, 32'(g.err), 32'(code != 2'd0));
    end
  endtask

  initial begin
    logic [31:0] a_cyc;
    logic [31:0] bnd[10];
    int n;
    in_valid = 1'b0; out_ready = 1'b1; pc_load = 1'b0; pc_init = '0;
    fmt = '0; opcode = '0; rd = '0; funct3 = '0; rs1 = '0; rs2 = '0; funct7 = '0; imm = '0;

    // Reset state
    #2;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_ins", out_ins, 32'd0);
    check_val("rst_out_pc", out_pc, 32'd0);
    check_val("rst_out_err", {30'd0, out_err, 1'b0} | {30'd0, err_code}, 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back I-type, unstalled latency
    chk_lat = 1'b1;
    req(3'd1, 7'h13, 5'd5, 3'd0, 5'd5, 5'd0, 7'd0, 32'd1, 1'b0, 32'd0);
    a_cyc = acc_cyc;
    req(3'd1, 7'h13, 5'd29, 3'd0, 5'd29, 5'd0, 7'd0, 32'd1, 1'b0, 32'd0);
    check_val("b2b_accept", acc_cyc, a_cyc + 32'd1);
    idle(4);
    expect_out("addi5", 32'h0012_8293, 32'h0, 2'd0);
    expect_out("addi29", 32'h001E_8E93, 32'h4, 2'd0);

    // SB and UJ offsets relative to a loaded PC
    req(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'h14, 1'b1, 32'h0C);
    req(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h78, 1'b1, 32'h7C);
    idle(4);
    expect_out("beq", 32'h0020_8463, 32'h0C, 2'd0);
    expect_out("jal", 32'hFFDF_F0EF, 32'h7C, 2'd0);

    // Error cases; PC keeps advancing by 4
    req(3'd1, 7'h13, 5'd1, 3'd0, 5'd1, 5'd0, 7'd0, 32'd2048, 1'b0, 32'd0);
    req(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'h87, 1'b0, 32'd0);
    req(3'd7, 7'h13, 5'd1, 3'd0, 5'd1, 5'd0, 7'd0, 32'd0, 1'b0, 32'd0);
    req(3'd1, 7'h13, 5'd1, 3'd0, 5'd1, 5'd0, 7'd0, 32'hFFFF_F800, 1'b0, 32'd0);
    idle(4);
    chk_lat = 1'b0;
    expect_out("err_range", 32'h0000_0013, 32'h80, 2'd1);
    expect_out("err_align", 32'h0000_0013, 32'h84, 2'd2);
    expect_out("err_fmt", 32'h0000_0013, 32'h88, 2'd3);
    expect_out("imm_min", 32'h8000_8093, 32'h8C, 2'd0);

    // Stall: 5 cycles of out_ready=0 with 3 requests
    out_ready = 1'b0;
    req(3'd1, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd10, 1'b0, 32'd0);
    req(3'd1, 7'h13, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'd11, 1'b0, 32'd0);
    set_req(3'd1, 7'h13, 5'd4, 3'd0, 5'd0, 5'd0, 7'd0, 32'd12, 1'b0, 32'd0);
    check_val("stall_in_ready", 32'(in_ready), 32'd0);
    idle(3);
    check_val("stall_no_accept", 32'(last_acc), 32'd0);
    out_ready = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!last_acc && n < 20);
    check_val("stall_third_accept", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
    idle(4);
    expect_out("stall_a", 32'h00A0_0113, 32'h90, 2'd0);
    expect_out("stall_b", 32'h00B0_0193, 32'h94, 2'd0);
    expect_out("stall_c", 32'h00C0_0213, 32'h98, 2'd0);

    // Reset pulse in the middle of a stall drops everything
    out_ready = 1'b0;
    req(3'd1, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd20, 1'b0, 32'd0);
    req(3'd1, 7'h13, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'd21, 1'b0, 32'd0);
    set_req(3'd1, 7'h13, 5'd4, 3'd0, 5'd0, 5'd0, 7'd0, 32'd22, 1'b0, 32'd0);
    cycle();
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    check_val("midrst_out_valid", 32'(out_valid), 32'd0);
    check_val("midrst_out_ins", out_ins, 32'd0);
    check_val("midrst_out_pc", out_pc, 32'd0);
    check_val("midrst_code", 32'(err_code), 32'd0);
    check_val("midrst_in_ready", 32'(in_ready), 32'd1);
    sb_q.delete(); stab_vld = 1'b0; mpc = 32'h0;
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    idle(4);
    check_val("midrst_nothing_out", 32'(got_q.size()), 32'd0);
    req(3'd1, 7'h13, 5'd1, 3'd0, 5'd1, 5'd0, 7'd0, 32'd5, 1'b0, 32'd0);
    idle(4);
    expect_out("after_rst", 32'h0050_8093, 32'h0, 2'd0);

    // Random traffic with boundary-heavy immediates and targets
    bnd[0] = 32'd2047;        bnd[1] = 32'd2048;        bnd[2] = -32'sd2048;  bnd[3] = -32'sd2049;
    bnd[4] = 32'd4094;        bnd[5] = 32'd4096;        bnd[6] = -32'sd4096;  bnd[7] = -32'sd4098;
    bnd[8] = 32'd1048574;     bnd[9] = 32'd1048576;
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      pc_load   = ($urandom_range(0, 15) == 0);
      pc_init   = $urandom & 32'hFFFF_FFFC;
      fmt       = 3'($urandom_range(0, 7));
      opcode    = 7'($urandom); rd = 5'($urandom); funct3 = 3'($urandom);
      rs1       = 5'($urandom); rs2 = 5'($urandom); funct7 = 7'($urandom);
      case ($urandom_range(0, 4))
        0: imm = 32'($urandom_range(0, 4200)) - 32'd2100;
        1: imm = bnd[$urandom_range(0, 9)];
        2: imm = mpc + 32'($urandom_range(0, 40)) - 32'd20;
        3: imm = mpc + bnd[$urandom_range(4, 9)] + 32'($urandom_range(0, 1));
        default: imm = ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFF_F000) : $urandom;
      endcase
      if (fmt >= 3'd6 || fmt == 3'd4) begin
        // keep bound-relative values meaningful for U too
        if ($urandom_range(0, 1) != 0) imm = imm & 32'hFFFF_F000;
      end
      cycle();
    end
    in_valid = 1'b0; pc_load = 1'b0; out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin cycle(); n++; end
    check_val("drain_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
